// File: rtl/board_io_pkg.sv
// Shared types and helpers for the board input front-end.
// Repeat FSM states, counter sizing and default parameter values.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_t;

    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 12500000;
    localparam int DEF_REPEAT_PERIOD   = 2500000;
    localparam bit DEF_BTN_ACTIVE_LOW  = 1'b0;
    localparam int DEF_HB_BITS         = 24;

    function automatic int cnt_w(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/board_button_channel.sv
// One button channel: synchroniser, debounce, press/release pulses
// and the hold-to-repeat state machine.
module board_button_channel
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DW   = cnt_w(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_w(RMAX);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          raw_ah;
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [DW-1:0] db_cnt;
    logic          accept;
    logic          acc_press;
    logic          acc_rel;

    assign raw_ah    = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign accept    = (sync2 != stable) && (db_cnt == DB_LAST);
    assign acc_press = accept & ~stable;
    assign acc_rel   = accept & stable;
    assign btn_level = stable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b0;
            db_cnt      <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= raw_ah;
            sync2       <= sync1;
            btn_press   <= acc_press;
            btn_release <= acc_rel;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt <= '0;
                stable <= ~stable;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    rpt_state_t    state;
    rpt_state_t    state_d;
    logic [RW-1:0] r_cnt;
    logic [RW-1:0] r_cnt_d;
    logic [RW-1:0] r_last;
    logic          rpt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            r_cnt      <= '0;
            btn_repeat <= 1'b0;
        end else begin
            state      <= state_d;
            r_cnt      <= r_cnt_d;
            btn_repeat <= rpt_d;
        end
    end

    // Release wins over a coinciding expiry; disable parks in HOLD at zero
    always_comb begin
        state_d = state;
        r_cnt_d = r_cnt;
        rpt_d   = 1'b0;
        r_last  = (state == HOLD) ? DELAY_LAST : PERIOD_LAST;
        unique case (state)
            IDLE: begin
                if (acc_press) begin
                    state_d = HOLD;
                    r_cnt_d = '0;
                    rpt_d   = 1'b1;
                end
            end
            HOLD, RPT: begin
                if (acc_rel) begin
                    state_d = IDLE;
                    r_cnt_d = '0;
                end else if (!repeat_en) begin
                    state_d = HOLD;
                    r_cnt_d = '0;
                end else if (r_cnt == r_last) begin
                    state_d = RPT;
                    r_cnt_d = '0;
                    rpt_d   = 1'b1;
                end else begin
                    r_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                r_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/board_button_conditioner.sv
// Board input front-end: N conditioned button channels plus the
// free-running heartbeat LED divider.
module board_button_conditioner
    import board_io_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW,
    parameter int HB_BITS         = DEF_HB_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             heartbeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        board_button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .repeat_en   (repeat_en[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

    logic [HB_BITS-1:0] hb_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign heartbeat = hb_cnt[HB_BITS-1];

endmodule
